// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state encoding and decode helper for the multicycle MIPS-subset controller.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12,
    S_IMM_EXEC  = 4'd13,
    S_IMM_WB    = 4'd14
  } state_t;

  // Which ALU operation source applies in the current state.
  typedef enum logic [1:0] {
    ACLS_ADD   = 2'd0,
    ACLS_FUNCT = 2'd1,
    ACLS_SUB   = 2'd2,
    ACLS_IMM   = 2'd3
  } alu_class_t;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [1:0] PC_SRC_OUT  = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;
  localparam logic [1:0] PC_SRC_REG  = 2'b11;

  // State following DECODE; S_FETCH marks an undecodable instruction.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    nxt = S_FETCH;
    case (op)
      OP_LW, OP_SW:    nxt = S_MEM_ADDR;
      OP_RTYPE: begin
        if (fn == FN_JR)
          nxt = S_JR;
        else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
          nxt = S_EXECUTE;
      end
      OP_BEQ, OP_BNE:  nxt = S_BRANCH;
      OP_J:            nxt = S_JUMP;
      OP_JAL:          nxt = S_JAL;
      OP_ADDI, OP_ORI: nxt = S_IMM_EXEC;
      default:         nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// ALU-control decode: maps (state class, opcode, funct) to alu_ctrl and zero_ext.
module alu_ctrl_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_ctrl,
  output logic        zero_ext
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    zero_ext = 1'b0;
    case (alu_class)
      ACLS_FUNCT: begin
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      ACLS_SUB: alu_ctrl = ALU_SUB;
      ACLS_IMM: begin
        if (opcode == OP_ORI) begin
          alu_ctrl = ALU_OR;
          zero_ext = 1'b1;
        end
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with ALU-control decode and retired-instruction counter.
// Define MC_CTRL_STALL_EN to make FETCH/MEM_READ/MEM_WRITE wait on mem_ready.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_write_cond_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             zero_ext,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t     cur_state, next_state, decode_target;
  alu_class_t alu_class;
  logic [2:0] dec_alu_ctrl;
  logic       mem_go;

  assign decode_target = decode_next(opcode, funct);
  assign state         = cur_state;

  // Memory handshake: memory-facing states complete in the cycle mem_ready is high;
  // until then the strobes stay asserted and every state-advancing effect is held off.
`ifdef MC_CTRL_STALL_EN
  assign mem_go = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cur_state <= S_IDLE;
    else
      cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:      next_state = S_FETCH;
      S_FETCH:     next_state = mem_go ? S_DECODE : S_FETCH;
      S_DECODE:    next_state = decode_target;
      S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = mem_go ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = mem_go ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next_state = S_R_WB;
      S_IMM_EXEC:  next_state = S_IMM_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_IMM_WB:
                   next_state = S_FETCH;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    reg_dst          = REG_DST_RT;
    mem_to_reg       = MEM_TO_REG_ALU;
    alu_src_b        = ALU_B_REG;
    pc_source        = PC_SRC_ALU;
    alu_class        = ACLS_ADD;
    retire           = 1'b0;
    illegal          = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        pc_write  = mem_go;
        ir_write  = mem_go;
        alu_src_b = ALU_B_FOUR;
      end
      S_DECODE: begin
        alu_src_b = ALU_B_BRANCH;
        illegal   = (decode_target == S_FETCH);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_MEM;
        reg_dst    = REG_DST_RT;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_go;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_class = ACLS_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = REG_DST_RD;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        alu_class        = ACLS_SUB;
        pc_source        = PC_SRC_OUT;
        pc_write_cond    = (opcode == OP_BEQ);
        pc_write_cond_ne = (opcode == OP_BNE);
        retire           = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        retire    = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = MEM_TO_REG_PC;
        retire     = 1'b1;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_REG;
        retire    = 1'b1;
      end
      // IMM_WB keeps the IMM_EXEC ALU setup so the result stays stable during write-back.
      S_IMM_EXEC, S_IMM_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        alu_class = ACLS_IMM;
        if (cur_state == S_IMM_WB) begin
          reg_write = 1'b1;
          reg_dst   = REG_DST_RT;
          retire    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  alu_ctrl_decoder u_alu_ctrl_decoder (
    .alu_class (alu_class),
    .opcode    (opcode),
    .funct     (funct),
    .alu_ctrl  (dec_alu_ctrl),
    .zero_ext  (zero_ext)
  );

  // IDLE drives every output to zero, including the ALU code.
  assign alu_ctrl = (cur_state == S_IDLE) ? 3'b000 : dec_alu_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_count <= '0;
    else if (retire)
      instr_count <= instr_count + CNT_W'(1);
  end

endmodule
